// File: rtl/rv32_fetch.sv
// Instruction-fetch front end: credit-limited request issue, in-order response
// capture into a small prefetch FIFO, and redirect handling with stale-response dropping.
module rv32_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic          started;
  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] total_out;
  logic [CW-1:0] count;
  logic [CW-1:0] drop_cnt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic [31:0]   redirect_target;
  logic [CW:0]   credit_used;
  logic          req_fire;
  logic          rsp_fire;
  logic          push;
  logic          pop;
  logic          unused_bits;

  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign unused_bits     = ^redirect_pc[1:0];
  assign credit_used     = {1'b0, total_out} + {1'b0, count};

  // Every accepted request owns a FIFO slot until it is popped or dropped.
  assign imem_req_valid = started && (credit_used < DEPTH_C) && !redirect_valid;
  assign imem_req_addr  = started ? fetch_pc : 32'h0;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_fire = imem_rsp_valid;
  assign push     = rsp_fire && (drop_cnt == '0) && !redirect_valid;
  assign pop      = if_valid && if_ready && !redirect_valid;

  assign if_valid = (count != '0);
  assign if_pc    = if_valid ? pc_mem[rd_ptr]    : 32'h0;
  assign if_instr = if_valid ? instr_mem[rd_ptr] : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started   <= 1'b0;
      fetch_pc  <= RESET_PC;
      rsp_pc    <= RESET_PC;
      total_out <= '0;
      count     <= '0;
      drop_cnt  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      started <= 1'b1;
      if (redirect_valid) begin
        // Everything still outstanding belongs to the old stream.
        fetch_pc  <= redirect_target;
        rsp_pc    <= redirect_target;
        total_out <= total_out - CW'(rsp_fire);
        drop_cnt  <= total_out - CW'(rsp_fire);
        count     <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        total_out <= total_out + CW'(req_fire) - CW'(rsp_fire);
        if (rsp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
          rsp_pc <= rsp_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= rsp_pc;
      instr_mem[wr_ptr] <= imem_rsp_data;
    end
  end

  assert property (@(posedge clk) disable iff (!rst) (push |-> ({1'b0, count} < DEPTH_C)));
  assert property (@(posedge clk) disable iff (!rst) (imem_rsp_valid |-> (total_out != '0)));

endmodule

// File: tb/tb_rv32_fetch.sv
// Randomized bench for rv32_fetch: transaction-level reference model with a
// per-cycle compare process, plus directed redirect/stall/reset scenarios.
module tb_rv32_fetch;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  always #5 clk = ~clk;

  rv32_fetch #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_instr(if_instr)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;

  // Instruction memory: word n holds n; responses in order, no earlier than lat cycles.
  typedef struct {logic [31:0] addr; int due;} mreq_t;
  mreq_t mq[$];
  int    last_due = 0;

  // Reference model state (stream-level view of the fetch unit).
  bit          m_started = 1'b0;
  logic [31:0] m_fetch = 32'h0;
  logic [31:0] m_rsp = 32'h0;
  int          m_total = 0;
  int          m_drop = 0;
  logic [63:0] m_q[$];

  logic [63:0] pop_log[$];
  int          pop_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr >> 2;
  endfunction

  always @(negedge clk) begin
    bit          mrv;
    bit          miv;
    logic [31:0] tgt;
    logic [63:0] head;
    int          due;
    if (!rst) begin
      chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
      chk("rst_req_addr", imem_req_addr, 32'h0);
      chk("rst_if_valid", 32'(if_valid), 32'h0);
      chk("rst_if_pc", if_pc, 32'h0);
      chk("rst_if_instr", if_instr, 32'h0);
      m_started = 1'b0; m_fetch = 32'h0; m_rsp = 32'h0;
      m_total = 0; m_drop = 0; m_q.delete();
    end else begin
      mrv = m_started && (m_total + m_q.size() < DEPTH) && !redirect_valid;
      miv = (m_q.size() != 0);
      chk("req_valid", 32'(imem_req_valid), 32'(mrv));
      if (mrv) chk("req_addr", imem_req_addr, m_fetch);
      if (!m_started) chk("first_cycle_addr", imem_req_addr, 32'h0);
      chk("if_valid", 32'(if_valid), 32'(miv));
      if (miv) begin
        head = m_q[0];
        chk("if_pc", if_pc, head[63:32]);
        chk("if_instr", if_instr, head[31:0]);
      end
      if (if_valid && if_ready && !redirect_valid) begin
        pop_log.push_back({if_pc, if_instr});
        pop_cyc.push_back(cyc);
      end
      if (imem_req_valid && imem_req_ready) begin
        due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        mq.push_back('{imem_req_addr, due});
        last_due = due;
      end
      if (redirect_valid) begin
        tgt = {redirect_pc[31:2], 2'b00};
        m_q.delete();
        m_fetch = tgt;
        m_rsp = tgt;
        if (imem_rsp_valid) m_total--;
        m_drop = m_total;
      end else begin
        if (miv && if_ready) void'(m_q.pop_front());
        if (imem_rsp_valid) begin
          m_total--;
          if (m_drop > 0) m_drop--;
          else begin
            m_q.push_back({m_rsp, mem_word(m_rsp)});
            m_rsp += 32'd4;
          end
        end
        if (mrv && imem_req_ready) begin
          m_fetch += 32'd4;
          m_total++;
        end
      end
      m_started = 1'b1;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    redirect_valid = 1'b0;
    if (rst && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  task automatic wait_pop(input int idx, input string name);
    int n;
    n = 0;
    while (pop_log.size() <= idx && n < 60) begin
      cycle();
      n++;
    end
    if (pop_log.size() <= idx) chk({name, "_timeout"}, 32'h1, 32'h0);
  endtask

  task automatic wait_first_req(input logic [31:0] exp, input string name);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      #1;
      if (imem_req_valid) begin
        chk(name, imem_req_addr, exp);
        got = 1'b1;
      end else begin
        cycle();
        n++;
      end
    end
    if (!got) chk({name, "_timeout"}, 32'h1, 32'h0);
  endtask

  initial begin
    int c0;
    int idx;
    int n;
    int breaks;
    logic [63:0] prev;
    logic [63:0] cur;

    // Reset release, latency 1, everyone ready.
    repeat (3) cycle();
    rst = 1'b1;
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    c0 = cyc;
    repeat (20) cycle();
    chk("phase1_enough_pops", 32'(pop_log.size() >= 3), 32'h1);
    if (pop_log.size() >= 3) begin
      chk("first_valid_cycle", 32'(pop_cyc[0] - c0), 32'd3);
      chk("pop0", pop_log[0][63:32], 32'h0);
      chk("pop0_instr", pop_log[0][31:0], 32'h0);
      chk("pop1", pop_log[1][63:32], 32'h4);
      chk("pop1_instr", pop_log[1][31:0], 32'h1);
      chk("pop2", pop_log[2][63:32], 32'h8);
      chk("pop2_instr", pop_log[2][31:0], 32'h2);
    end

    // Decode stall: FIFO fills, requests stop.
    if_ready = 1'b0;
    repeat (10) cycle();
    #1;
    chk("stall_req_valid", 32'(imem_req_valid), 32'h0);
    chk("stall_if_valid", 32'(if_valid), 32'h1);
    chk("stall_model_full", 32'(m_q.size()), 32'd2);
    if_ready = 1'b1;
    repeat (10) cycle();
    breaks = 0;
    for (int i = 1; i < pop_log.size(); i++) begin
      prev = pop_log[i-1];
      cur  = pop_log[i];
      if (cur[63:32] != prev[63:32] + 32'd4 || cur[31:0] != mem_word(cur[63:32])) breaks++;
    end
    chk("stall_seq_breaks", 32'(breaks), 32'h0);

    // Redirect with two requests in flight at latency 3.
    lat = 3;
    n = 0;
    while (!(m_total == 2 && !imem_rsp_valid) && n < 40) begin
      cycle();
      n++;
    end
    chk("redir1_setup", 32'(m_total), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    idx = pop_log.size();
    cycle();
    chk("redir1_drop", 32'(m_drop), 32'd2);
    wait_pop(idx, "redir1_pop");
    if (pop_log.size() > idx) begin
      chk("redir1_pc", pop_log[idx][63:32], 32'h100);
      chk("redir1_instr", pop_log[idx][31:0], 32'h40);
    end

    // Redirect in the same cycle as an arriving response, one in flight.
    lat = 1;
    n = 0;
    cycle();
    while (!(m_total == 1 && imem_rsp_valid) && n < 40) begin
      cycle();
      n++;
    end
    chk("redir2_setup", 32'(m_total), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    idx = pop_log.size();
    cycle();
    chk("redir2_drop", 32'(m_drop), 32'd0);
    wait_first_req(32'h200, "redir2_req_addr");
    wait_pop(idx, "redir2_pop");
    if (pop_log.size() > idx) begin
      chk("redir2_pc", pop_log[idx][63:32], 32'h200);
      chk("redir2_instr", pop_log[idx][31:0], 32'h80);
    end

    // Memory ready toggling every cycle.
    for (int i = 0; i < 30; i++) begin
      cycle();
      imem_req_ready = cyc[0];
      lat = $urandom_range(1, 2);
    end

    // Fully random traffic with occasional redirects, including address wrap.
    for (int i = 0; i < 400; i++) begin
      cycle();
      imem_req_ready = ($urandom_range(0, 3) != 0);
      if_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) lat = $urandom_range(1, 4);
      if ($urandom_range(0, 15) == 0) begin
        redirect_valid = 1'b1;
        if ($urandom_range(0, 1) == 0) redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        else redirect_pc = $urandom;
      end
    end

    // Reset while data is buffered and a request is in flight.
    imem_req_ready = 1'b1;
    if_ready = 1'b0;
    lat = 2;
    n = 0;
    while (!(m_q.size() >= 1 && m_total >= 1) && n < 40) begin
      cycle();
      n++;
    end
    chk("rst_setup", 32'(m_q.size() >= 1 && m_total >= 1), 32'h1);
    rst = 1'b0;
    mq.delete();
    last_due = 0;
    imem_rsp_valid = 1'b0;
    #1;
    chk("midrst_if_valid", 32'(if_valid), 32'h0);
    chk("midrst_req_valid", 32'(imem_req_valid), 32'h0);
    repeat (3) cycle();
    rst = 1'b1;
    if_ready = 1'b1;
    wait_first_req(32'h0, "post_rst_addr");
    repeat (10) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
